arith_share_sched: RTL and testbench
====================================

// Module: arith_share_sched
// PURPOSE
//  Shares one pipelined arithmetic unit (montgomery mult, adder_pipe or subtractor_pipe) between NUM_IN multiexp cores.
//  Uses round-robin issue, tags the ctl field with the requester index and routes results back by that tag.
//  Per-requester credit counters bound in-flight ops, so one core cannot fill the unit and stall result return.
//  Sits between the multiexp cores and each shared arithmetic unit in a core group.
// PARAMETERS
//  NUM_IN     4    number of requesters (>=2)
//  REQ_BITS   762  request data width (two operands, 2*DAT_BITS)
//  RES_BITS   381  result data width
//  CTL_BITS   11   ctl width carried through the unit
//  TAG_LSB    8    lowest ctl bit overwritten with requester index; TAG_BITS = max(1,$clog2(NUM_IN))
//  MAX_OUT    8    max in-flight ops per requester (>=1)
// PORTS
//  i_clk        in   1                  clock
//  i_rst_n      in   1                  async active-low reset
//  i_req_val    in   NUM_IN             request valid per requester
//  i_req_dat    in   NUM_IN*REQ_BITS    request operands
//  i_req_ctl    in   NUM_IN*CTL_BITS    request ctl
//  o_req_rdy    out  NUM_IN             request accept per requester
//  o_unit_val   out  1                  to unit: valid
//  o_unit_dat   out  REQ_BITS           to unit: operands
//  o_unit_ctl   out  CTL_BITS           to unit: ctl with tag inserted
//  i_unit_rdy   in   1                  unit ready
//  i_res_val    in   1                  from unit: result valid
//  i_res_dat    in   RES_BITS           from unit: result
//  i_res_ctl    in   CTL_BITS           from unit: ctl carrying tag
//  o_res_rdy    out  1                  result accept
//  o_rsp_val    out  NUM_IN             result valid per requester
//  o_rsp_dat    out  RES_BITS           result data, broadcast to all requesters
//  o_rsp_ctl    out  CTL_BITS           result ctl as received, tag intact
//  i_rsp_rdy    in   NUM_IN             requester accepts result
//  o_err        out  1                  one-cycle pulse on protocol error
// BEHAVIOUR
//  Reset (async, i_rst_n=0): o_unit_val=0, RR pointer=0, all credits=0, o_err=0; comb outputs follow from these.
//  Issue: eligible[k] = i_req_val[k] && credit[k]<MAX_OUT; grant = first eligible at or after pointer, wrapping.
//  One output register stage. It loads when empty or i_unit_rdy; o_req_rdy[grant] is comb in that case, all others 0.
//  Request accepted in cycle t -> o_unit_val=1 in t+1; sustained throughput 1 op/cycle.
//  On accept from k: pointer <= (k+1)%NUM_IN; o_unit_ctl = i_req_ctl[k] with [TAG_LSB+:TAG_BITS] replaced by k.
//  Register holds dat/ctl stable while o_unit_val && !i_unit_rdy.
//  Return: tag t = i_res_ctl[TAG_LSB+:TAG_BITS]; o_rsp_val[t]=i_res_val; o_res_rdy=i_rsp_rdy[t]. Purely comb, 0 latency.
//  Credit[k]: +1 on accept from k, -1 on result handshake with tag k; both in same cycle -> unchanged.
//  Credit==MAX_OUT: k is skipped by arbitration; pointer does not stall on it.
//  Tag >= NUM_IN (non-pow2 NUM_IN): o_res_rdy=1, result dropped, o_err pulses.
//  Result for k while credit[k]==0: delivered, credit stays 0 (no underflow), o_err pulses.
//  No eligible requester: pointer holds. Reset mid-operation discards the output register and all credits.
//  Unit results still in flight after reset arrive at 0 credit and raise o_err; the integrator drains the unit first.
// CONFIGURATION
//  ARITH_SHARE_STATS_EN defined: adds o_stat_grant[NUM_IN*32] and o_stat_stall[NUM_IN*32].
//    grant = accepts per requester; stall = cycles with i_req_val && !o_req_rdy.
//    32-bit saturating counters, cleared by reset and by input i_stat_clr (sync).
//  Undefined: those ports and counters are absent; functional behaviour is identical.
// STRUCTURE
//  Shared package arith_share_pkg: tag width function, stat counter typedef, err cause enum (BAD_TAG, CREDIT_UFL).
//  One sub-module rr_arbiter #(N): req vector + pointer -> one-hot grant and index; pointer update lives here.
// TESTING
//  1 NUM_IN=4, all val, unit rdy=1, 8 cycles -> grants 0,1,2,3,0,1,2,3; tags in o_unit_ctl match; 1 op/cycle.
//  2 i_unit_rdy=0 for 5 cycles mid-stream -> o_unit_dat/ctl stable, no o_req_rdy, order resumes unchanged.
//  3 only req 2 active, unit never returns, MAX_OUT=8 -> exactly 8 accepts, then o_req_rdy[2]=0;
//    one result tag 2 -> one more accept.
//  4 results tags 3,0,3 with i_rsp_rdy[3]=0 for 2 cycles -> o_res_rdy=0 those cycles; each result to the right requester only.
//  5 NUM_IN=3, inject tag 3 -> o_res_rdy=1, no o_rsp_val, o_err=1 one cycle; tag 1 at credit 0 -> delivered, o_err.
//  6 assert i_rst_n=0 mid-burst -> o_unit_val=0 and credits=0 immediately; after release grant restarts at 0.

Source files
------------

// File: rtl/arith_share_pkg.sv
// Shared types for the arithmetic-unit share scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: requester tag width function, statistics counter type,
// protocol error cause encoding.
package arith_share_pkg;

  // Statistics counters are fixed 32-bit saturating counters.
  typedef logic [31:0] stat_cnt_t;

  // Protocol error causes seen on the result return path.
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    BAD_TAG    = 2'd1,
    CREDIT_UFL = 2'd2
  } err_cause_e;

  // Width of the requester index carried in ctl; never narrower than 1 bit.
  function automatic int tag_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arith_share_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping.
// Latency: grant is combinational; the pointer updates on the clock after an accepted grant.
// Backpressure: pointer holds while advance is low or nothing requests.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (pointer -> 0)
//   req[N]       eligible requesters
//   advance      grant is being consumed this cycle
//   gnt[N]       one-hot grant (all zero when no request)
//   gnt_idx      binary index of the granted requester
//   any          at least one request present
module rr_arbiter
  import arith_share_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  input  logic                    advance,
  output logic [N-1:0]            gnt,
  output logic [tag_bits(N)-1:0]  gnt_idx,
  output logic                    any
);

  localparam int IW = tag_bits(N);

  logic [IW-1:0] ptr;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

  // Next search starts just past the winner, so a requester that is skipped
  // (not requesting or out of credit) never stalls the rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arith_share_sched.sv
// Shares one pipelined arithmetic unit among NUM_IN requesters: RR issue, tag-routed results, per-requester credits.
// Latency: request accepted in cycle t appears at the unit in t+1; results return combinationally (0 cycles).
// Backpressure: output register holds while the unit is not ready; result rdy follows the tagged requester's rdy.
//
// Optional feature macro: ARITH_SHARE_STATS_EN adds i_stat_clr, o_stat_grant, o_stat_stall.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_req_val/dat/ctl, o_req_rdy      per-requester request channel (flattened, requester k at slice k)
//   o_unit_val/dat/ctl, i_unit_rdy    issue channel to the shared unit, ctl carries requester tag
//   i_res_val/dat/ctl, o_res_rdy      result channel from the unit
//   o_rsp_val[k], o_rsp_dat/ctl, i_rsp_rdy[k]  per-requester result delivery, data/ctl broadcast
//   o_err                             one-cycle pulse on bad tag or credit underflow
module arith_share_sched
  import arith_share_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int REQ_BITS = 762,
  parameter int RES_BITS = 381,
  parameter int CTL_BITS = 11,
  parameter int TAG_LSB  = 8,
  parameter int MAX_OUT  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_IN-1:0]            i_req_val,
  input  logic [NUM_IN*REQ_BITS-1:0]   i_req_dat,
  input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
  output logic [NUM_IN-1:0]            o_req_rdy,
  output logic                         o_unit_val,
  output logic [REQ_BITS-1:0]          o_unit_dat,
  output logic [CTL_BITS-1:0]          o_unit_ctl,
  input  logic                         i_unit_rdy,
  input  logic                         i_res_val,
  input  logic [RES_BITS-1:0]          i_res_dat,
  input  logic [CTL_BITS-1:0]          i_res_ctl,
  output logic                         o_res_rdy,
  output logic [NUM_IN-1:0]            o_rsp_val,
  output logic [RES_BITS-1:0]          o_rsp_dat,
  output logic [CTL_BITS-1:0]          o_rsp_ctl,
  input  logic [NUM_IN-1:0]            i_rsp_rdy,
  output logic                         o_err
`ifdef ARITH_SHARE_STATS_EN
  ,
  input  logic                         i_stat_clr,
  output logic [NUM_IN*32-1:0]         o_stat_grant,
  output logic [NUM_IN*32-1:0]         o_stat_stall
`endif
);

  localparam int TAG_BITS = tag_bits(NUM_IN);
  localparam int CW       = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  logic [CW-1:0]        credit [NUM_IN];
  logic [NUM_IN-1:0]    eligible;
  logic [NUM_IN-1:0]    gnt;
  logic [TAG_BITS-1:0]  gnt_idx;
  logic                 any;
  logic                 load;
  logic                 accept;
  logic [REQ_BITS-1:0]  sel_dat;
  logic [CTL_BITS-1:0]  sel_ctl;
  logic [TAG_BITS-1:0]  res_tag;
  logic                 tag_ok;
  logic [NUM_IN-1:0]    ret;
  logic [NUM_IN-1:0]    inc;
  logic [NUM_IN-1:0]    dec;
  logic [NUM_IN-1:0]    ufl;
  err_cause_e           err_cause;

  // ---------------- issue side ----------------
  // A requester at its in-flight limit is simply invisible to the arbiter.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      eligible[k] = i_req_val[k] && (credit[k] < MAX_C);
    end
  end

  // The single output stage can take a new op when empty or draining this cycle.
  assign load   = !o_unit_val || i_unit_rdy;
  assign accept = load && any;

  rr_arbiter #(.N(NUM_IN)) u_arb (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .req     (eligible),
    .advance (load),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign o_req_rdy = load ? gnt : '0;

  // Mux the winner's operands and stamp its index into the tag field.
  always_comb begin
    sel_dat = '0;
    sel_ctl = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (gnt[k]) begin
        sel_dat = i_req_dat[k*REQ_BITS +: REQ_BITS];
        sel_ctl = i_req_ctl[k*CTL_BITS +: CTL_BITS];
      end
    end
    sel_ctl[TAG_LSB +: TAG_BITS] = gnt_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_unit_val <= 1'b0;
    end else if (load) begin
      o_unit_val <= any;
    end
  end

  // Payload needs no reset: it is qualified by o_unit_val.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      o_unit_dat <= sel_dat;
      o_unit_ctl <= sel_ctl;
    end
  end

  // ---------------- return side ----------------
  assign res_tag   = i_res_ctl[TAG_LSB +: TAG_BITS];
  assign tag_ok    = (int'(res_tag) < NUM_IN);
  assign o_rsp_dat = i_res_dat;
  assign o_rsp_ctl = i_res_ctl;

  // A tag that names no requester is swallowed (rdy=1) so the unit never wedges.
  always_comb begin
    o_rsp_val = '0;
    o_res_rdy = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (tag_ok && (res_tag == TAG_BITS'(k))) begin
        o_rsp_val[k] = i_res_val;
        o_res_rdy    = i_rsp_rdy[k];
      end
    end
  end

  assign ret = o_rsp_val & {NUM_IN{o_res_rdy}};

  // ---------------- credits ----------------
  // A return at zero credit is still delivered but must not wrap the counter.
  always_comb begin
    inc = '0;
    dec = '0;
    ufl = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      inc[k] = accept && gnt[k];
      ufl[k] = ret[k] && (credit[k] == '0);
      dec[k] = ret[k] && (credit[k] != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_IN; k++) credit[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (inc[k] && !dec[k]) begin
          credit[k] <= credit[k] + 1'b1;
        end else if (dec[k] && !inc[k]) begin
          credit[k] <= credit[k] - 1'b1;
        end
      end
    end
  end

  // ---------------- error pulse ----------------
  always_comb begin
    err_cause = ERR_NONE;
    if (i_res_val && !tag_ok) begin
      err_cause = BAD_TAG;
    end else if (|ufl) begin
      err_cause = CREDIT_UFL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else begin
      o_err <= (err_cause != ERR_NONE);
    end
  end

`ifdef ARITH_SHARE_STATS_EN
  // ---------------- statistics ----------------
  for (genvar k = 0; k < NUM_IN; k++) begin : g_stat
    stat_cnt_t grant_cnt;
    stat_cnt_t stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        grant_cnt <= '0;
        stall_cnt <= '0;
      end else if (i_stat_clr) begin
        grant_cnt <= '0;
        stall_cnt <= '0;
      end else begin
        if (inc[k] && (grant_cnt != '1)) begin
          grant_cnt <= grant_cnt + 1'b1;
        end
        if (i_req_val[k] && !o_req_rdy[k] && (stall_cnt != '1)) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end

    assign o_stat_grant[k*32 +: 32] = grant_cnt;
    assign o_stat_stall[k*32 +: 32] = stall_cnt;
  end
`endif

endmodule

// File: tb/tb_arith_share_sched.sv
// Self-checking bench for arith_share_sched: a 4-requester instance against a
// transaction-level model, and a 3-requester instance for out-of-range tags.
module tb_arith_share_sched;

  localparam int N   = 4;
  localparam int RB  = 32;
  localparam int SB  = 16;
  localparam int CB  = 11;
  localparam int MAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 4-requester instance ----------------
  logic [N-1:0]    req_val;
  logic [N*RB-1:0] req_dat;
  logic [N*CB-1:0] req_ctl;
  logic [N-1:0]    o_req_rdy;
  logic            o_unit_val;
  logic [RB-1:0]   o_unit_dat;
  logic [CB-1:0]   o_unit_ctl;
  logic            unit_rdy;
  logic            res_val;
  logic [SB-1:0]   res_dat;
  logic [CB-1:0]   res_ctl;
  logic            o_res_rdy;
  logic [N-1:0]    o_rsp_val;
  logic [SB-1:0]   o_rsp_dat;
  logic [CB-1:0]   o_rsp_ctl;
  logic [N-1:0]    rsp_rdy;
  logic            o_err;

  arith_share_sched #(.NUM_IN(N), .REQ_BITS(RB), .RES_BITS(SB), .CTL_BITS(CB),
                      .TAG_LSB(8), .MAX_OUT(MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_val(req_val), .i_req_dat(req_dat), .i_req_ctl(req_ctl), .o_req_rdy(o_req_rdy),
    .o_unit_val(o_unit_val), .o_unit_dat(o_unit_dat), .o_unit_ctl(o_unit_ctl), .i_unit_rdy(unit_rdy),
    .i_res_val(res_val), .i_res_dat(res_dat), .i_res_ctl(res_ctl), .o_res_rdy(o_res_rdy),
    .o_rsp_val(o_rsp_val), .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl), .i_rsp_rdy(rsp_rdy),
    .o_err(o_err)
  );

  // ---------------- 3-requester instance ----------------
  logic [2:0]    b_req_val = '0;
  logic [3*RB-1:0] b_req_dat = '0;
  logic [3*CB-1:0] b_req_ctl = '0;
  logic [2:0]    b_req_rdy;
  logic          b_unit_val;
  logic [RB-1:0] b_unit_dat;
  logic [CB-1:0] b_unit_ctl;
  logic          b_res_val = 1'b0;
  logic [SB-1:0] b_res_dat = '0;
  logic [CB-1:0] b_res_ctl = '0;
  logic          b_res_rdy;
  logic [2:0]    b_rsp_val;
  logic [SB-1:0] b_rsp_dat;
  logic [CB-1:0] b_rsp_ctl;
  logic [2:0]    b_rsp_rdy = '0;
  logic          b_err;

  arith_share_sched #(.NUM_IN(3), .REQ_BITS(RB), .RES_BITS(SB), .CTL_BITS(CB),
                      .TAG_LSB(8), .MAX_OUT(MAX)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_val(b_req_val), .i_req_dat(b_req_dat), .i_req_ctl(b_req_ctl), .o_req_rdy(b_req_rdy),
    .o_unit_val(b_unit_val), .o_unit_dat(b_unit_dat), .o_unit_ctl(b_unit_ctl), .i_unit_rdy(1'b1),
    .i_res_val(b_res_val), .i_res_dat(b_res_dat), .i_res_ctl(b_res_ctl), .o_res_rdy(b_res_rdy),
    .o_rsp_val(b_rsp_val), .o_rsp_dat(b_rsp_dat), .o_rsp_ctl(b_rsp_ctl), .i_rsp_rdy(b_rsp_rdy),
    .o_err(b_err)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: in-flight count per requester, rotation start, what sits at the unit.
  int            m_cred [N];
  int            m_ptr;
  logic          m_uval;
  logic [RB-1:0] m_udat;
  logic [CB-1:0] m_uctl;
  logic          m_err;
  int            dut_acc [N];   // accepts observed on the DUT handshake
  int            tbl_exp = -2;  // -2: no table expectation this cycle

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_cred[k] = 0;
    m_ptr = 0; m_uval = 1'b0; m_udat = '0; m_uctl = '0; m_err = 1'b0;
  endtask

  task automatic rand_payload();
    for (int k = 0; k < N; k++) begin
      req_dat[k*RB +: RB] = $urandom;
      req_ctl[k*CB +: CB] = CB'($urandom);
    end
  endtask

  // Entered at posedge+1 with inputs applied; checks at negedge, advances model at posedge.
  task automatic cycle();
    int g;
    int tag;
    logic exp_res_rdy;
    logic [N-1:0] exp_rsp;
    @(negedge clk);
    g = -1;
    if (!m_uval || unit_rdy) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (g < 0 && req_val[k] && m_cred[k] < MAX) g = k;
      end
    end
    chk("req_rdy", 64'(o_req_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (tbl_exp != -2)
      chk("tbl_grant", 64'(o_req_rdy), (tbl_exp >= 0) ? (64'd1 << tbl_exp) : 64'd0);
    chk("unit_val", 64'(o_unit_val), 64'(m_uval));
    if (m_uval) begin
      chk("unit_dat", 64'(o_unit_dat), 64'(m_udat));
      chk("unit_ctl", 64'(o_unit_ctl), 64'(m_uctl));
    end
    tag         = (int'(res_ctl) >> 8) % N;
    exp_res_rdy = rsp_rdy[tag];
    exp_rsp     = res_val ? N'(1 << tag) : '0;
    chk("rsp_val", 64'(o_rsp_val), 64'(exp_rsp));
    chk("res_rdy", 64'(o_res_rdy), 64'(exp_res_rdy));
    chk("err", 64'(o_err), 64'(m_err));
    if (res_val) begin
      chk("rsp_dat", 64'(o_rsp_dat), 64'(res_dat));
      chk("rsp_ctl", 64'(o_rsp_ctl), 64'(res_ctl));
    end
    for (int k = 0; k < N; k++)
      if (req_val[k] && o_req_rdy[k]) dut_acc[k]++;
    @(posedge clk);
    m_err = 1'b0;
    if (res_val && exp_res_rdy) begin
      if (m_cred[tag] == 0) m_err = 1'b1;
      else m_cred[tag]--;
    end
    if (g >= 0) begin
      m_uval = 1'b1;
      m_udat = req_dat[g*RB +: RB];
      m_uctl = (req_ctl[g*CB +: CB] & ~CB'(11'h300)) | CB'(g << 8);
      m_cred[g]++;
      m_ptr = (g + 1) % N;
    end else if (unit_rdy) begin
      m_uval = 1'b0;
    end
    #1;
  endtask

  // Entered at posedge+1; in reset the unit stage is empty and the lowest valid requester wins.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #2;
    chk({nm, "_unit_val"}, 64'(o_unit_val), 64'd0);
    chk({nm, "_err"}, 64'(o_err), 64'd0);
    chk({nm, "_req_rdy"}, 64'(o_req_rdy), 64'(req_val & (~req_val + 4'd1)));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] val;
    logic         urdy;
    int           g;
  } vec_t;

  vec_t tbl[$];

  task automatic run_table();
    foreach (tbl[i]) begin
      req_val  = tbl[i].val;
      unit_rdy = tbl[i].urdy;
      tbl_exp  = tbl[i].g;
      rand_payload();
      cycle();
    end
    tbl_exp = -2;
    tbl.delete();
  endtask

  initial begin
    req_val = '0; req_dat = '0; req_ctl = '0; unit_rdy = 1'b1;
    res_val = 1'b0; res_dat = '0; res_ctl = '0; rsp_rdy = '0;
    for (int k = 0; k < N; k++) dut_acc[k] = 0;
    #1;
    do_reset("init");

    // 1+2: full rotation, then a 5-cycle unit stall that must freeze the stage
    for (int i = 0; i < 8; i++) tbl.push_back('{4'hF, 1'b1, i % 4});
    for (int i = 0; i < 5; i++) tbl.push_back('{4'hF, 1'b0, -1});
    for (int i = 0; i < 3; i++) tbl.push_back('{4'hF, 1'b1, i});
    tbl.push_back('{4'h0, 1'b1, -1});
    run_table();

    // 3: lone requester runs into its credit limit, one return frees one slot
    req_val = '0;
    do_reset("t3rst");
    for (int k = 0; k < N; k++) dut_acc[k] = 0;
    req_val = 4'b0100; unit_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin rand_payload(); cycle(); end
    chk("t3_accepts_at_limit", 64'(dut_acc[2]), 64'd8);
    res_val = 1'b1; res_ctl = 11'h200; res_dat = 16'h1234; rsp_rdy = 4'b0100;
    cycle();
    res_val = 1'b0;
    for (int i = 0; i < 4; i++) begin rand_payload(); cycle(); end
    chk("t3_accepts_after_return", 64'(dut_acc[2]), 64'd9);

    // 4: results 3,0,3 with requester 3 holding off for two cycles
    req_val = '0;
    do_reset("t4rst");
    req_val = 4'b1001;
    for (int i = 0; i < 4; i++) begin rand_payload(); cycle(); end
    req_val = '0;
    begin
      int          tg [5] = '{3, 3, 3, 0, 3};
      logic [3:0]  rr [5] = '{4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
      for (int i = 0; i < 5; i++) begin
        res_val = 1'b1;
        res_ctl = (CB'($urandom) & ~CB'(11'h300)) | CB'(tg[i] << 8);
        res_dat = SB'($urandom);
        rsp_rdy = rr[i];
        cycle();
      end
    end
    res_val = 1'b0;
    cycle();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      int t;
      req_val  = N'($urandom);
      unit_rdy = ($urandom_range(0, 9) < 7);
      rsp_rdy  = N'($urandom);
      rand_payload();
      res_val  = 1'b0;
      t = $urandom_range(0, N - 1);
      if ($urandom_range(0, 2) != 0 && (m_cred[t] > 0 || $urandom_range(0, 15) == 0)) begin
        res_val = 1'b1;
        res_ctl = (CB'($urandom) & ~CB'(11'h300)) | CB'(t << 8);
        res_dat = SB'($urandom);
      end
      cycle();
    end
    res_val = 1'b0;

    // 6: reset in the middle of a burst, rotation restarts at 0
    req_val = 4'hF; unit_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_payload(); cycle(); end
    do_reset("t6rst");
    for (int i = 0; i < 4; i++) tbl.push_back('{4'hF, 1'b1, i});
    run_table();
    req_val = '0;
    cycle();

    // 5: 3-requester instance, out-of-range tag and return at zero credit
    b_res_val = 1'b1; b_res_ctl = 11'h305; b_res_dat = 16'hBEEF; b_rsp_rdy = 3'b000;
    @(negedge clk);
    chk("t5_badtag_res_rdy", 64'(b_res_rdy), 64'd1);
    chk("t5_badtag_rsp_val", 64'(b_rsp_val), 64'd0);
    chk("t5_badtag_err_pre", 64'(b_err), 64'd0);
    @(posedge clk); #1;
    b_res_val = 1'b0;
    @(negedge clk);
    chk("t5_badtag_err", 64'(b_err), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_err_one_cycle", 64'(b_err), 64'd0);
    chk("t5_unit_idle", 64'(b_unit_val), 64'd0);
    @(posedge clk); #1;
    b_res_val = 1'b1; b_res_ctl = 11'h105; b_rsp_rdy = 3'b101;
    @(negedge clk);
    chk("t5_tag1_wait_rdy", 64'(b_res_rdy), 64'd0);
    chk("t5_tag1_wait_val", 64'(b_rsp_val), 64'b010);
    @(posedge clk); #1;
    b_rsp_rdy = 3'b010;
    @(negedge clk);
    chk("t5_ufl_rsp_val", 64'(b_rsp_val), 64'b010);
    chk("t5_ufl_res_rdy", 64'(b_res_rdy), 64'd1);
    chk("t5_ufl_rsp_dat", 64'(b_rsp_dat), 64'hBEEF);
    chk("t5_ufl_rsp_ctl", 64'(b_rsp_ctl), 64'h105);
    chk("t5_ufl_no_err_yet", 64'(b_err), 64'd0);
    @(posedge clk); #1;
    b_res_val = 1'b0;
    @(negedge clk);
    chk("t5_ufl_err", 64'(b_err), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_ufl_err_clear", 64'(b_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
